handwrite_preproc: RTL and testbench
====================================

Name: handwrite_preproc

Overview:
- Downstream consumer of the 900-bit handwriting bitmap produced by the cursor/handwrite stage.
- The bitmap is 30x30; bit index = row*30 + col.
- On a start pulse the block snapshots the bitmap, scans it for the bounding box of set pixels, then streams a 28x28 crop centred on that box.
- Output is an 8-bit pixel stream with valid/ready handshake, feeding the digit classifier.

Parameters:
- SRC_DIM, 30, source bitmap side length (bitmap width SRC_DIM*SRC_DIM).
- OUT_DIM, 28, output crop side length.
- PIX_ON, 8'hFF, intensity emitted for a set pixel.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  one-cycle request to process the current bitmap.
- i_bitmap  input  900  handwriting bitmap, bit row*30+col.
- o_busy  output  1  high in any state other than IDLE.
- o_pix  output  8  current output pixel (PIX_ON or 0).
- o_pix_row  output  5  output row 0..27 of the current pixel.
- o_pix_col  output  5  output column 0..27 of the current pixel.
- o_pix_last  output  1  high with pixel (27,27).
- o_pix_valid  output  1  pixel valid.
- i_pix_ready  input  1  downstream accepts the pixel.
- o_empty  output  1  last snapshot had no set pixel; held until the next accepted start.
- o_done  output  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Single clock i_clk; asynchronous active-high reset i_rst.
- Reset values:
  - State IDLE.
  - o_busy, o_pix_valid, o_pix_last, o_done, o_empty = 0.
  - o_pix, o_pix_row, o_pix_col = 0.
  - Snapshot register cleared.
- Reset asserted mid-operation aborts immediately, with no further pixels and no o_done.
- IDLE:
  - i_start=1 latches i_bitmap into the snapshot, clears o_empty, and goes to SCAN.
  - Bounding box initialised to min_r=min_c=29, max_r=max_c=0, found=0.
  - i_start is ignored in every other state.
- SCAN:
  - Visits one snapshot bit per cycle, row-major, via row/col counters 0..29 (900 cycles).
  - A set bit updates min/max row/col and sets found.
  - Goes to CALC after (29,29).
  - The live i_bitmap is never read after the snapshot is taken.
- CALC (1 cycle):
  - If found: off_r = ((min_r+max_r)>>1) - 13 and off_c = ((min_c+max_c)>>1) - 13, both signed 6-bit, range -13..16.
  - If not found: off_r = off_c = 1 and o_empty is set.
  - Output row/col counters are reset to 0; next state is STREAM.
- STREAM:
  - o_pix_valid=1. src_r = o_pix_row + off_r, src_c = o_pix_col + off_c, computed as signed 7-bit.
  - o_pix = PIX_ON if 0<=src_r<=29, 0<=src_c<=29 and the snapshot bit is set; otherwise 0.
  - Advance on o_pix_valid && i_pix_ready, row-major, col wrapping 27->0 with row+1.
  - While valid && !ready, o_pix, o_pix_row, o_pix_col and o_pix_last hold stable.
  - Acceptance of (27,27) returns the state to IDLE; o_pix_valid drops and o_done pulses for one cycle on the same edge.
- Latency:
  - Let E0 be the edge that samples i_start.
  - o_pix_valid rises after edge E0+901 (900 SCAN + 1 CALC).
  - With ready held high, the stream takes 784 cycles, and o_done is high after edge E0+1685.
- i_start asserted in the same cycle that o_done pulses is accepted (state is already IDLE).
- o_pix_row/o_pix_col and o_pix_last read 0 outside STREAM.

Test Plan:
- Reset check: i_rst=1 mid-SCAN and mid-STREAM -> all outputs 0 and o_busy=0 next cycle; no o_done; a fresh start afterwards works normally.
- Single pixel at (row 5, col 20), ready=1 -> off_r=-8, off_c=7; exactly one o_pix=8'hFF at output (13,13); 783 zeros; o_pix_last on (27,27); o_done high after edge E0+1685.
- Empty bitmap -> o_empty=1; all 784 pixels 0; o_empty stays 1 until the next start.
- Corners (0,0) and (29,29) set -> off=1 both axes; no output pixel maps to a set pixel, so all 784 are 0; o_empty=0.
- Backpressure: block at (10,3..12), i_pix_ready toggling 1/0 -> scoreboard sees 784 unique (row,col) transfers in order with identical data to the ready=1 run; outputs stable during stalls.
- Snapshot/ignore: change i_bitmap and pulse i_start during SCAN and STREAM -> no restart; output matches the bitmap latched at E0.

Source files
------------

// File: rtl/handwrite_preproc_if.sv
// Pixel stream from handwrite_preproc to the digit classifier.
//   o_pix        8-bit pixel intensity
//   o_pix_row    output row 0..27 of o_pix
//   o_pix_col    output column 0..27 of o_pix
//   o_pix_last   marks pixel (27,27)
//   o_pix_valid  pixel valid
//   i_pix_ready  consumer accepts the pixel
// master: the preprocessor (drives pixels); slave: the consumer.
interface handwrite_preproc_if;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned CRD_W = 5;

  logic [PIX_W-1:0] o_pix;
  logic [CRD_W-1:0] o_pix_row;
  logic [CRD_W-1:0] o_pix_col;
  logic             o_pix_last;
  logic             o_pix_valid;
  logic             i_pix_ready;

  modport master (
    output o_pix, o_pix_row, o_pix_col, o_pix_last, o_pix_valid,
    input  i_pix_ready
  );

  modport slave (
    input  o_pix, o_pix_row, o_pix_col, o_pix_last, o_pix_valid,
    output i_pix_ready
  );
endinterface

// File: rtl/handwrite_preproc.sv
// Handwriting preprocessor: snapshots the 30x30 bitmap on i_start, scans it
// for the bounding box of set pixels, then streams a 28x28 crop centred on
// that box over a valid/ready pixel interface.
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_start        one-cycle request to process i_bitmap (accepted in IDLE)
//   i_bitmap       source bitmap, bit row*30+col
//   o_busy         high whenever not IDLE
//   o_empty        last snapshot had no set pixel (held until next start)
//   o_done         one-cycle pulse after the last pixel is accepted
//   bus            pixel stream (master side)
module handwrite_preproc #(
  parameter int unsigned SRC_DIM = 30,
  parameter int unsigned OUT_DIM = 28,
  parameter logic [7:0]  PIX_ON  = 8'hFF
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [SRC_DIM*SRC_DIM-1:0]   i_bitmap,
  output logic                         o_busy,
  output logic                         o_empty,
  output logic                         o_done,
  handwrite_preproc_if.master          bus
);

  localparam int unsigned NBITS = SRC_DIM * SRC_DIM;
  localparam int unsigned IDX_W = $clog2(NBITS);
  localparam int unsigned CW    = 5;
  localparam int unsigned OFF_W = 6;
  localparam int unsigned SRC_W = 7;
  localparam logic [CW-1:0]    SRC_LAST = CW'(SRC_DIM - 1);
  localparam logic [CW-1:0]    OUT_LAST = CW'(OUT_DIM - 1);
  localparam logic [OFF_W-1:0] CENTER   = OFF_W'(OUT_DIM / 2 - 1);

  typedef enum logic [1:0] {IDLE, SCAN, CALC, STREAM} state_t;

  state_t state, state_nxt;

  logic [NBITS-1:0]        snap;
  logic [CW-1:0]           scan_r, scan_c;
  logic [CW-1:0]           min_r, min_c, max_r, max_c;
  logic                    found;
  logic signed [OFF_W-1:0] off_r, off_c;

  logic                    accept;
  logic                    scan_bit;
  logic                    scan_end;
  logic [CW:0]             sum_r, sum_c;
  logic [CW-1:0]           mid_r, mid_c;
  logic signed [OFF_W-1:0] calc_off_r, calc_off_c;
  logic [CW-1:0]           adv_row, adv_col;

  logic [CW-1:0]           lk_row, lk_col;
  logic signed [OFF_W-1:0] lk_off_r, lk_off_c;
  logic signed [SRC_W-1:0] lk_src_r, lk_src_c;
  logic                    lk_in;
  logic [IDX_W-1:0]        lk_idx;
  logic [7:0]              lk_pix;

  logic                    nxt_busy, nxt_valid, nxt_last, nxt_done, nxt_empty;
  logic [7:0]              nxt_pix;
  logic [CW-1:0]           nxt_row, nxt_col;

  assign accept   = bus.o_pix_valid && bus.i_pix_ready;
  assign scan_end = (scan_r == SRC_LAST) && (scan_c == SRC_LAST);
  assign scan_bit = snap[IDX_W'(scan_r) * IDX_W'(SRC_DIM) + IDX_W'(scan_c)];

  // Crop offset: box centre minus (OUT_DIM/2 - 1); an empty box uses 1
  always_comb begin
    sum_r      = (CW+1)'(min_r) + (CW+1)'(max_r);
    sum_c      = (CW+1)'(min_c) + (CW+1)'(max_c);
    mid_r      = CW'(sum_r >> 1);
    mid_c      = CW'(sum_c >> 1);
    calc_off_r = OFF_W'(1);
    calc_off_c = OFF_W'(1);
    if (found) begin
      calc_off_r = OFF_W'(mid_r) - CENTER;
      calc_off_c = OFF_W'(mid_c) - CENTER;
    end
  end

  // Row-major successor of the current output coordinate
  always_comb begin
    adv_col = (bus.o_pix_col == OUT_LAST) ? '0 : bus.o_pix_col + CW'(1);
    adv_row = (bus.o_pix_col == OUT_LAST) ? bus.o_pix_row + CW'(1) : bus.o_pix_row;
  end

  // Snapshot lookup for the pixel about to be presented: (0,0) with the fresh
  // offsets while in CALC, otherwise the successor with the latched offsets
  always_comb begin
    lk_row   = adv_row;
    lk_col   = adv_col;
    lk_off_r = off_r;
    lk_off_c = off_c;
    if (state == CALC) begin
      lk_row   = '0;
      lk_col   = '0;
      lk_off_r = calc_off_r;
      lk_off_c = calc_off_c;
    end
    lk_src_r = $signed({2'b00, lk_row}) + SRC_W'(lk_off_r);
    lk_src_c = $signed({2'b00, lk_col}) + SRC_W'(lk_off_c);
    lk_in    = !lk_src_r[SRC_W-1] && (lk_src_r[SRC_W-2:0] <= (SRC_W-1)'(SRC_DIM - 1)) &&
               !lk_src_c[SRC_W-1] && (lk_src_c[SRC_W-2:0] <= (SRC_W-1)'(SRC_DIM - 1));
    lk_idx   = IDX_W'(lk_src_r[CW-1:0]) * IDX_W'(SRC_DIM) + IDX_W'(lk_src_c[CW-1:0]);
    lk_pix   = (lk_in && snap[lk_idx]) ? PIX_ON : 8'h00;
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = SCAN;
      SCAN:    if (scan_end) state_nxt = CALC;
      CALC:    state_nxt = STREAM;
      STREAM:  if (accept && bus.o_pix_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    nxt_busy  = (state_nxt != IDLE);
    nxt_valid = bus.o_pix_valid;
    nxt_pix   = bus.o_pix;
    nxt_row   = bus.o_pix_row;
    nxt_col   = bus.o_pix_col;
    nxt_last  = bus.o_pix_last;
    nxt_done  = 1'b0;
    nxt_empty = o_empty;
    case (state)
      IDLE: if (i_start) nxt_empty = 1'b0;
      CALC: begin
        nxt_valid = 1'b1;
        nxt_pix   = lk_pix;
        nxt_row   = '0;
        nxt_col   = '0;
        nxt_last  = 1'b0;
        if (!found) nxt_empty = 1'b1;
      end
      STREAM: begin
        if (accept) begin
          if (bus.o_pix_last) begin
            nxt_valid = 1'b0;
            nxt_pix   = '0;
            nxt_row   = '0;
            nxt_col   = '0;
            nxt_last  = 1'b0;
            nxt_done  = 1'b1;
          end else begin
            nxt_pix   = lk_pix;
            nxt_row   = adv_row;
            nxt_col   = adv_col;
            nxt_last  = (adv_row == OUT_LAST) && (adv_col == OUT_LAST);
          end
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_busy          <= 1'b0;
      o_empty         <= 1'b0;
      o_done          <= 1'b0;
      bus.o_pix_valid <= 1'b0;
      bus.o_pix       <= '0;
      bus.o_pix_row   <= '0;
      bus.o_pix_col   <= '0;
      bus.o_pix_last  <= 1'b0;
    end else begin
      o_busy          <= nxt_busy;
      o_empty         <= nxt_empty;
      o_done          <= nxt_done;
      bus.o_pix_valid <= nxt_valid;
      bus.o_pix       <= nxt_pix;
      bus.o_pix_row   <= nxt_row;
      bus.o_pix_col   <= nxt_col;
      bus.o_pix_last  <= nxt_last;
    end
  end

  // Snapshot, scan counters, bounding box and crop offsets
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      snap   <= '0;
      scan_r <= '0;
      scan_c <= '0;
      min_r  <= SRC_LAST;
      min_c  <= SRC_LAST;
      max_r  <= '0;
      max_c  <= '0;
      found  <= 1'b0;
      off_r  <= '0;
      off_c  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            snap   <= i_bitmap;
            scan_r <= '0;
            scan_c <= '0;
            min_r  <= SRC_LAST;
            min_c  <= SRC_LAST;
            max_r  <= '0;
            max_c  <= '0;
            found  <= 1'b0;
          end
        end
        SCAN: begin
          if (scan_bit) begin
            found <= 1'b1;
            if (scan_r < min_r) min_r <= scan_r;
            if (scan_r > max_r) max_r <= scan_r;
            if (scan_c < min_c) min_c <= scan_c;
            if (scan_c > max_c) max_c <= scan_c;
          end
          if (scan_c == SRC_LAST) begin
            scan_c <= '0;
            scan_r <= scan_r + CW'(1);
          end else begin
            scan_c <= scan_c + CW'(1);
          end
        end
        CALC: begin
          off_r <= calc_off_r;
          off_c <= calc_off_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_handwrite_preproc.sv
// Directed bench for handwrite_preproc: table of bitmaps with hand-computed
// crop offsets and set-pixel counts, plus reset-abort and empty-hold sequences.
module tb_handwrite_preproc;

  localparam int unsigned SRC_DIM = 30;
  localparam int unsigned OUT_DIM = 28;
  localparam int unsigned NBITS   = SRC_DIM * SRC_DIM;
  localparam int unsigned NPIX    = OUT_DIM * OUT_DIM;
  localparam int unsigned NVEC    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [NBITS-1:0] bitmap = '0;
  logic             busy, empty, done;

  handwrite_preproc_if bus();

  handwrite_preproc dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_bitmap(bitmap),
    .o_busy  (busy),
    .o_empty (empty),
    .o_done  (done),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    string name;
    int    ra0, ra1, ca0, ca1;
    bit    has_b;
    int    rb0, rb1, cb0, cb1;
    int    off_r, off_c;
    int    ones;
    bit    exp_empty;
    bit    toggle;
    bit    disturb;
  } vec_t;

  function automatic vec_t mk(input string name,
                              input int ra0, input int ra1, input int ca0, input int ca1,
                              input bit has_b,
                              input int rb0, input int rb1, input int cb0, input int cb1,
                              input int off_r, input int off_c, input int ones,
                              input bit exp_empty, input bit toggle, input bit disturb);
    vec_t v;
    v.name = name; v.ra0 = ra0; v.ra1 = ra1; v.ca0 = ca0; v.ca1 = ca1;
    v.has_b = has_b; v.rb0 = rb0; v.rb1 = rb1; v.cb0 = cb0; v.cb1 = cb1;
    v.off_r = off_r; v.off_c = off_c; v.ones = ones;
    v.exp_empty = exp_empty; v.toggle = toggle; v.disturb = disturb;
    return v;
  endfunction

  function automatic logic [NBITS-1:0] build(input vec_t v);
    logic [NBITS-1:0] bm;
    bm = '0;
    for (int r = v.ra0; r <= v.ra1; r++)
      for (int c = v.ca0; c <= v.ca1; c++)
        bm[r*SRC_DIM + c] = 1'b1;
    if (v.has_b)
      for (int r = v.rb0; r <= v.rb1; r++)
        for (int c = v.cb0; c <= v.cb1; c++)
          bm[r*SRC_DIM + c] = 1'b1;
    return bm;
  endfunction

  function automatic int exp_pix(input logic [NBITS-1:0] bm, input int r, input int c,
                                 input int orr, input int oc);
    int sr, sc;
    sr = r + orr;
    sc = c + oc;
    if (sr < 0 || sr >= int'(SRC_DIM) || sc < 0 || sc >= int'(SRC_DIM)) return 0;
    return bm[sr*SRC_DIM + sc] ? 255 : 0;
  endfunction

  // Run one vector; entered and left at a falling edge. On exit o_done is high,
  // so a following call drives i_start in the o_done cycle.
  task automatic run_vec(input vec_t v);
    logic [NBITS-1:0] bm;
    int e0, k, ones, first_valid, guard, s_pix, s_row, s_col, s_last;
    bit stalled, tog, rdy;
    bm = build(v);
    bitmap = bm;
    start = 1'b1;
    @(negedge clk);
    e0 = cyc;
    start = 1'b0;
    chk({v.name, " busy_after_start"}, int'(busy), 1);
    chk({v.name, " empty_cleared"}, int'(empty), 0);
    chk({v.name, " scan_valid"}, int'(bus.o_pix_valid), 0);
    chk({v.name, " scan_row_col_last"},
        int'(bus.o_pix_row) + int'(bus.o_pix_col) + int'(bus.o_pix_last), 0);
    k = 0; ones = 0; first_valid = -1; guard = 0; stalled = 1'b0; tog = 1'b0;
    s_pix = 0; s_row = 0; s_col = 0; s_last = 0;
    while (k < int'(NPIX) && guard < 4000) begin
      if (v.disturb) begin
        if (cyc == e0 + 100 || cyc == e0 + 1200) begin
          bitmap = '1;
          start  = 1'b1;
        end else begin
          start  = 1'b0;
        end
      end
      if (bus.o_pix_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (stalled) begin
          chk({v.name, " stall_pix"},  int'(bus.o_pix), s_pix);
          chk({v.name, " stall_row"},  int'(bus.o_pix_row), s_row);
          chk({v.name, " stall_col"},  int'(bus.o_pix_col), s_col);
          chk({v.name, " stall_last"}, int'(bus.o_pix_last), s_last);
        end
        rdy = v.toggle ? tog : 1'b1;
        tog = !tog;
        bus.i_pix_ready = rdy;
        if (rdy) begin
          chk({v.name, " row"},  int'(bus.o_pix_row), k / int'(OUT_DIM));
          chk({v.name, " col"},  int'(bus.o_pix_col), k % int'(OUT_DIM));
          chk({v.name, " pix"},  int'(bus.o_pix),
              exp_pix(bm, k / int'(OUT_DIM), k % int'(OUT_DIM), v.off_r, v.off_c));
          chk({v.name, " last"}, int'(bus.o_pix_last), (k == int'(NPIX) - 1) ? 1 : 0);
          if (bus.o_pix == 8'hFF) ones++;
          k++;
        end
        stalled = !rdy;
        s_pix = int'(bus.o_pix); s_row = int'(bus.o_pix_row);
        s_col = int'(bus.o_pix_col); s_last = int'(bus.o_pix_last);
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    bus.i_pix_ready = 1'b1;
    chk({v.name, " pixels_transferred"}, k, int'(NPIX));
    chk({v.name, " done_pulse"}, int'(done), 1);
    chk({v.name, " valid_dropped"}, int'(bus.o_pix_valid), 0);
    chk({v.name, " busy_dropped"}, int'(busy), 0);
    chk({v.name, " ones"}, ones, v.ones);
    chk({v.name, " empty"}, int'(empty), int'(v.exp_empty));
    if (!v.toggle) begin
      chk({v.name, " valid_latency"}, first_valid - e0, 901);
      chk({v.name, " done_latency"}, cyc - e0, 1685);
    end
  endtask

  // Abort a run with reset after wait_cyc cycles and check that it stays quiet
  task automatic reset_mid(input string tag, input logic [NBITS-1:0] bm,
                           input int wait_cyc, input bit in_stream);
    int seen;
    bitmap = bm;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (wait_cyc) @(negedge clk);
    chk({tag, " busy_before_reset"}, int'(busy), 1);
    chk({tag, " valid_before_reset"}, int'(bus.o_pix_valid), int'(in_stream));
    rst = 1'b1;
    @(negedge clk);
    chk({tag, " busy"},  int'(busy), 0);
    chk({tag, " valid"}, int'(bus.o_pix_valid), 0);
    chk({tag, " pix"},   int'(bus.o_pix), 0);
    chk({tag, " row"},   int'(bus.o_pix_row), 0);
    chk({tag, " col"},   int'(bus.o_pix_col), 0);
    chk({tag, " last"},  int'(bus.o_pix_last), 0);
    chk({tag, " done"},  int'(done), 0);
    chk({tag, " empty"}, int'(empty), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || bus.o_pix_valid || busy) seen++;
    end
    chk({tag, " quiet_after_reset"}, seen, 0);
  endtask

  vec_t vecs [NVEC];

  initial begin
    vecs[0] = mk("single",  5, 5, 20, 20, 0, 0, 0, 0, 0,  -8,  7,   1, 0, 0, 0);
    vecs[1] = mk("empty",   1, 0,  1,  0, 0, 0, 0, 0, 0,   1,  1,   0, 1, 0, 0);
    vecs[2] = mk("corners", 0, 0,  0,  0, 1,29,29,29,29,   1,  1,   0, 0, 0, 0);
    vecs[3] = mk("blk_dist",10,10, 3, 12, 0, 0, 0, 0, 0,  -3, -6,  10, 0, 0, 1);
    vecs[4] = mk("blk_bp", 10,10,  3, 12, 0, 0, 0, 0, 0,  -3, -6,  10, 0, 1, 0);
    vecs[5] = mk("full",    0,29,  0, 29, 0, 0, 0, 0, 0,   1,  1, 784, 0, 0, 0);
    vecs[6] = mk("botrt",  28,29, 27, 29, 0, 0, 0, 0, 0,  15, 15,   6, 0, 0, 0);
    vecs[7] = mk("topleft", 0, 0,  0,  0, 0, 0, 0, 0, 0, -13,-13,   1, 0, 0, 0);

    bus.i_pix_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy",  int'(busy), 0);
    chk("reset valid", int'(bus.o_pix_valid), 0);
    chk("reset pix",   int'(bus.o_pix), 0);
    chk("reset rowcol", int'(bus.o_pix_row) + int'(bus.o_pix_col), 0);
    chk("reset last",  int'(bus.o_pix_last), 0);
    chk("reset done",  int'(done), 0);
    chk("reset empty", int'(empty), 0);
    rst = 1'b0;
    @(negedge clk);

    reset_mid("rst_scan",   build(vecs[0]), 200,  1'b0);
    reset_mid("rst_stream", build(vecs[1]), 1000, 1'b1);

    for (int i = 0; i < int'(NVEC); i++) begin
      run_vec(vecs[i]);
      if (i == 1) begin
        repeat (5) @(negedge clk);
        chk("empty_hold", int'(empty), 1);
        chk("done_single_cycle", int'(done), 0);
      end
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
